keypad_scan: RTL
================

KEYPAD_SCAN -- requirements
Module: keypad_scan

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 5000: clk cycles per scan tick.
REQ-002 SHALL have parameter DEBOUNCE_CNT, default 4: consecutive stable ticks required to accept a press or a release.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on posedge clk.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port row, input, 4: keypad rows, active-low (1111 = no key).
REQ-006 SHALL have port col, output, 4: column drive, exactly one bit low at any time.
REQ-007 SHALL have port clear, input, 1: synchronous clear of number.
REQ-008 SHALL have port number, output, 16: last four accepted hex digits, newest in [3:0], for the display block.
REQ-009 SHALL have port key_code, output, 4: code of the last accepted key.
REQ-010 SHALL have port key_valid, output, 1: one-cycle pulse on each accepted key.
REQ-011 SHALL have port key_held, output, 1: high while in HELD or RELEASE.

Function
REQ-012 SHALL generate tick as a one-cycle pulse: tick_cnt counts 0..SCAN_DIV-1, and tick fires when tick_cnt = SCAN_DIV-1, then tick_cnt wraps to 0.
REQ-013 SHALL use FSM states SCAN, DEBOUNCE, HELD and RELEASE.
REQ-014 SCAN: on each tick, col SHALL rotate 1110 -> 1101 -> 1011 -> 0111 -> 1110; row SHALL be sampled on the same tick, before the rotation.
REQ-015 SCAN: a tick sample with exactly one row bit low SHALL capture row, freeze col, clear deb_cnt and go to DEBOUNCE; zero or two or more low row bits SHALL be ignored.
REQ-016 DEBOUNCE: on each tick, row equal to the captured row SHALL increment deb_cnt; any other value SHALL return to SCAN with col resuming rotation.
REQ-017 DEBOUNCE: on the tick where deb_cnt reaches DEBOUNCE_CNT, the block SHALL pulse key_valid, update key_code, set number <= {number[11:0], code} and go to HELD.
REQ-018 Key encoding SHALL be code = 4*row_idx + col_idx, where row_idx and col_idx are the bit positions (0..3) of the low row bit and low col bit.
REQ-019 HELD: col SHALL stay frozen; a tick with row = 1111 SHALL clear deb_cnt and go to RELEASE; otherwise the FSM stays in HELD.
REQ-020 RELEASE: a tick with row = 1111 SHALL increment deb_cnt; any low row bit SHALL return to HELD without emitting key_valid; deb_cnt reaching DEBOUNCE_CNT SHALL go to SCAN with col advancing at the next tick.
REQ-021 A held key SHALL produce exactly one key_valid; there is no auto-repeat.
REQ-022 clear SHALL set number to 0 in the next cycle in any state.
REQ-023 If clear and the key_valid shift occur in the same cycle, clear SHALL win for number, while key_valid and key_code still update.
REQ-024 key_valid latency SHALL be DEBOUNCE_CNT ticks after the capturing tick.
REQ-025 All outputs SHALL be registered.

Reset
REQ-026 reset SHALL force state = SCAN, col = 1110, tick_cnt = 0, deb_cnt = 0, number = 0, key_code = 0, key_valid = 0, key_held = 0.
REQ-027 reset asserted mid-DEBOUNCE or mid-HELD SHALL discard the pending key with no key_valid; after release, scanning restarts from col = 1110.

Structure
REQ-028 The shared package SHALL hold the state encoding, the four column patterns and the row-idle constant 1111.
REQ-029 The tick divider SHALL be one sub-module, scan_tick(clk, reset, tick), parameterised by SCAN_DIV.

Verification (SCAN_DIV=4, DEBOUNCE_CNT=2)
REQ-030 Press row1/col2 (row=1101), stable 6 ticks, then release -> one key_valid, key_code=6, number=0x0006.
REQ-031 Keys 1, 2, 3, 4, 5 in sequence, each with a clean press and release -> number=0x2345 after the fifth key (0x0001 dropped); key_valid pulses 5 times.
REQ-032 Bounce: row low for 1 tick, then high -> no key_valid, FSM back in SCAN, col rotating again.
REQ-033 Two rows low at once (row=1001) -> no capture, no key_valid.
REQ-034 clear asserted in the same cycle as the key_valid for key 0xF, with number=0x1234 -> number=0x0000, key_code=0xF, key_valid pulses once.
REQ-035 reset asserted during HELD -> all outputs 0, col=1110; the key then held 10 ticks after reset release -> exactly one key_valid.

Source files
------------

// File: rtl/keypad_scan_pkg.sv
// Shared definitions for the 4x4 keypad scanner.
//   state_e   : scanner FSM encoding
//   COL_PATS  : the four active-low column drive patterns, index = column
//   ROW_IDLE  : row value with no key pressed
// Helpers: col_next (rotation), one_low (exactly one low bit), low_idx
// (position of the low bit in a one-low vector).
package keypad_scan_pkg;

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2,
    ST_RELEASE  = 2'd3
  } state_e;

  localparam logic [3:0][3:0] COL_PATS = {4'b0111, 4'b1011, 4'b1101, 4'b1110};
  localparam logic [3:0]      ROW_IDLE = 4'b1111;

  // Any value outside the four legal patterns falls back to column 0,
  // so the drive self-heals instead of ever driving two columns low.
  function automatic logic [3:0] col_next(input logic [3:0] c);
    logic [3:0] n;
    n = COL_PATS[0];
    for (int i = 0; i < 4; i++)
      if (c == COL_PATS[i]) n = COL_PATS[(i + 1) % 4];
    return n;
  endfunction

  function automatic logic one_low(input logic [3:0] v);
    return ($countones(~v) == 1);
  endfunction

  function automatic logic [1:0] low_idx(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < 4; i++)
      if (!v[i]) idx = 2'(i);
    return idx;
  endfunction

endpackage

// File: rtl/keypad_scan_tick.sv
// Scan tick divider.
//   clk, reset : clock, async active-high reset
//   tick       : one-cycle pulse every SCAN_DIV clocks (on count SCAN_DIV-1)
module scan_tick #(
  parameter int SCAN_DIV = 5000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [CW-1:0] tick_cnt_q, tick_cnt_d;

  always_comb begin
    tick       = (tick_cnt_q == CW'(SCAN_DIV - 1));
    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) tick_cnt_q <= '0;
    else       tick_cnt_q <= tick_cnt_d;
  end

endmodule

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner with debounce and a 4-digit hex history.
//   clk, reset : clock, async active-high reset
//   row        : active-low row sense (1111 = idle)
//   col        : active-low column drive, exactly one bit low
//   clear      : synchronous clear of number (wins over a same-cycle shift)
//   number     : last four accepted codes, newest in [3:0]
//   key_code   : code of last accepted key (4*row_idx + col_idx)
//   key_valid  : one-cycle pulse per accepted key
//   key_held   : high while in HELD or RELEASE
// All FSM activity advances only on scan ticks; clear acts every cycle.
module keypad_scan
  import keypad_scan_pkg::*;
#(
  parameter int SCAN_DIV     = 5000,
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  row,
  output logic [3:0]  col,
  input  logic        clear,
  output logic [15:0] number,
  output logic [3:0]  key_code,
  output logic        key_valid,
  output logic        key_held
);

  localparam int DW = $clog2(DEBOUNCE_CNT + 1);

  logic tick;

  state_e        state_q, state_d;
  logic [3:0]    col_q, col_d;
  logic [3:0]    row_cap_q, row_cap_d;
  logic [DW-1:0] deb_cnt_q, deb_cnt_d;
  logic [15:0]   number_q, number_d;
  logic [3:0]    key_code_q, key_code_d;
  logic          key_valid_q, key_valid_d;
  logic          key_held_q, key_held_d;

  logic [DW-1:0] deb_inc;
  logic          deb_done;
  logic [3:0]    code;

  scan_tick #(.SCAN_DIV(SCAN_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_cap_d   = row_cap_q;
    deb_cnt_d   = deb_cnt_q;
    number_d    = number_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;

    deb_inc  = deb_cnt_q + 1'b1;
    deb_done = (deb_inc == DW'(DEBOUNCE_CNT));
    // col is frozen from capture onward, so it still names the pressed column
    code     = {low_idx(row_cap_q), low_idx(col_q)};

    if (tick) begin
      unique case (state_q)
        ST_SCAN: begin
          if (one_low(row)) begin
            row_cap_d = row;
            deb_cnt_d = '0;
            state_d   = ST_DEBOUNCE;
          end else begin
            col_d = col_next(col_q);
          end
        end
        ST_DEBOUNCE: begin
          if (row == row_cap_q) begin
            deb_cnt_d = deb_inc;
            if (deb_done) begin
              key_valid_d = 1'b1;
              key_code_d  = code;
              number_d    = {number_q[11:0], code};
              state_d     = ST_HELD;
            end
          end else begin
            // bounce: drop the candidate, rotation resumes from SCAN
            state_d = ST_SCAN;
          end
        end
        ST_HELD: begin
          if (row == ROW_IDLE) begin
            deb_cnt_d = '0;
            state_d   = ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (row == ROW_IDLE) begin
            deb_cnt_d = deb_inc;
            if (deb_done) state_d = ST_SCAN;
          end else begin
            // release bounce goes back to HELD; no second key_valid
            state_d = ST_HELD;
          end
        end
        default: state_d = ST_SCAN;
      endcase
    end

    if (clear) number_d = '0;

    key_held_d = (state_d == ST_HELD) || (state_d == ST_RELEASE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_SCAN;
      col_q       <= COL_PATS[0];
      row_cap_q   <= ROW_IDLE;
      deb_cnt_q   <= '0;
      number_q    <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_cap_q   <= row_cap_d;
      deb_cnt_q   <= deb_cnt_d;
      number_q    <= number_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
    end
  end

  assign col       = col_q;
  assign number    = number_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;

endmodule
